// File: rtl/audio_sample_packer_pkg.sv
// Shared types for the HDMI audio sample packer: group record, layout and
// fill-state enums, IEC 60958 block length.
package hdmi_audio_pkg;

    localparam int IEC_FRAMES_PER_BLOCK = 192;

    // One Audio Sample Packet worth of samples: 4 subpackets of an L/R pair.
    typedef struct packed {
        logic [3:0][1:0][23:0] sample;
        logic [3:0]            present;
        logic [3:0]            frame_start;
        logic [7:0]            frame_counter;
    } audio_group_t;

    typedef enum logic {
        LAYOUT_0 = 1'b0,
        LAYOUT_1 = 1'b1
    } audio_layout_e;

    // Packer state is the index of the next subpacket to fill in layout 0.
    typedef enum logic [1:0] {
        FILL_0 = 2'd0,
        FILL_1 = 2'd1,
        FILL_2 = 2'd2,
        FILL_3 = 2'd3
    } fill_state_e;

endpackage

// File: rtl/audio_sample_packer_if.sv
// Sample input and group output bundle of the audio sample packer.
// Handshake: in_valid is a one-cycle strobe with no back-pressure; a group
// transfers on the output whenever out_valid & out_ready are both high at a
// clk_audio edge, out_valid never depends on out_ready, and the out_* payload
// stays stable (and is zero) while out_valid is low.
interface audio_sample_packer_if #(
    parameter int AUDIO_BIT_WIDTH = 16,
    parameter int CHANNELS        = 2
);
    logic                                     in_valid;
    logic [CHANNELS-1:0][AUDIO_BIT_WIDTH-1:0] in_sample;
    logic                                     flush;
    logic                                     out_valid;
    logic                                     out_ready;
    logic [3:0][1:0][23:0]                    out_sample;
    logic [3:0]                               out_present;
    logic [3:0]                               out_frame_start;
    logic [7:0]                               out_frame_counter;
    logic                                     out_layout;
    logic [15:0]                              overflow_count;

    // Sample source / group consumer side.
    modport master (
        output in_valid, in_sample, flush, out_ready,
        input  out_valid, out_sample, out_present, out_frame_start,
               out_frame_counter, out_layout, overflow_count
    );

    // Packer side.
    modport slave (
        input  in_valid, in_sample, flush, out_ready,
        output out_valid, out_sample, out_present, out_frame_start,
               out_frame_counter, out_layout, overflow_count
    );
endinterface

// File: rtl/audio_sample_packer_fifo.sv
// audio_group_fifo: single-clock first-word-fall-through FIFO of audio groups.
// A push while full is accepted only when a pop happens in the same cycle.
module audio_group_fifo
    import hdmi_audio_pkg::*;
#(
    parameter int  DEPTH = 4,
    parameter type T     = audio_group_t
) (
    input  logic clk_audio,
    input  logic reset,
    input  logic push,
    input  T     push_data,
    input  logic pop,
    output T     head,
    output logic full,
    output logic empty
);
    localparam int AW = $clog2(DEPTH);

    T              mem [DEPTH];
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    logic [AW:0]   count;
    logic          do_push;
    logic          do_pop;

    assign empty   = (count == '0);
    assign full    = (count == (AW+1)'(DEPTH));
    assign do_pop  = pop & ~empty;
    assign do_push = push & (~full | do_pop);
    assign head    = mem[rd_ptr];

    // Pointer and occupancy bookkeeping.
    always_ff @(posedge clk_audio) begin
        if (reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + 1'b1;
            if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
            case ({do_push, do_pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    // Storage write; contents are don't-care until a slot is pushed.
    always_ff @(posedge clk_audio) begin
        if (do_push) mem[wr_ptr] <= push_data;
    end

endmodule

// File: rtl/audio_sample_packer.sv
// audio_sample_packer: left-justifies audio samples to 24 b, tracks the
// IEC 60958 frame number and groups samples into HDMI Audio Sample Packet
// groups (layout 0 for 2 ch, layout 1 for 4/6/8 ch) buffered in a FIFO.
// Optional feature macro: AUDIO_SAMPLE_PACKER_PARTIAL_FLUSH_EN enables
// flushing a partially filled layout-0 group.
module audio_sample_packer
    import hdmi_audio_pkg::*;
#(
    parameter int AUDIO_BIT_WIDTH = 16,
    parameter int CHANNELS        = 2,
    parameter int DEPTH           = 4
) (
    input  logic                  clk_audio,
    input  logic                  reset,
    audio_sample_packer_if.slave  bus,
    output fill_state_e           dbg_fill_state
);
    localparam audio_layout_e LAYOUT = (CHANNELS > 2) ? LAYOUT_1 : LAYOUT_0;

    fill_state_e      fill_state, nxt_state;
    audio_group_t     acc, nxt_acc, cap_group, push_group, head;
    logic [7:0]       frame_cnt, nxt_frame;
    logic [7:0][23:0] words;
    logic             push, pop, full, empty, drop;
    logic             unused_flush;

    assign unused_flush = bus.flush;
    assign pop          = bus.out_ready & ~empty;
    assign drop         = push & full & ~pop;

    // Left-justify every channel into a fixed 8-slot array.
    always_comb begin
        words = '0;
        for (int c = 0; c < CHANNELS; c++) begin
            words[c] = 24'(bus.in_sample[c]) << (24 - AUDIO_BIT_WIDTH);
        end
    end

    // State register: fill index, partial group and frame counter.
    always_ff @(posedge clk_audio) begin
        if (reset) begin
            fill_state <= FILL_0;
            acc        <= '0;
            frame_cnt  <= '0;
        end else begin
            fill_state <= nxt_state;
            acc        <= nxt_acc;
            frame_cnt  <= nxt_frame;
        end
    end

    // Next state: capture the sample, decide whether a group is pushed.
    always_comb begin
        nxt_state  = fill_state;
        nxt_acc    = acc;
        nxt_frame  = frame_cnt;
        cap_group  = acc;
        push_group = '0;
        push       = 1'b0;
        if (bus.in_valid) begin
            nxt_frame = (frame_cnt == 8'(IEC_FRAMES_PER_BLOCK - 1)) ? 8'd0 : frame_cnt + 8'd1;
            if (LAYOUT == LAYOUT_1) begin
                for (int i = 0; i < 4; i++) begin
                    if (i < CHANNELS / 2) begin
                        push_group.sample[i][0]   = words[2*i];
                        push_group.sample[i][1]   = words[2*i+1];
                        push_group.present[i]     = 1'b1;
                        push_group.frame_start[i] = (frame_cnt == 8'd0);
                    end
                end
                push_group.frame_counter = frame_cnt;
                push = 1'b1;
            end else begin
                cap_group.sample[fill_state][0]   = words[0];
                cap_group.sample[fill_state][1]   = words[1];
                cap_group.present[fill_state]     = 1'b1;
                cap_group.frame_start[fill_state] = (frame_cnt == 8'd0);
                if (fill_state == FILL_0) cap_group.frame_counter = frame_cnt;
                if (fill_state == FILL_3) begin
                    push_group = cap_group;
                    push       = 1'b1;
                    nxt_state  = FILL_0;
                    nxt_acc    = '0;
                end else begin
                    nxt_state = fill_state_e'(fill_state + 2'd1);
                    nxt_acc   = cap_group;
                end
            end
        end
`ifdef AUDIO_SAMPLE_PACKER_PARTIAL_FLUSH_EN
        // Flush applies after any coincident sample; absent subpackets are already zero.
        if (LAYOUT == LAYOUT_0 && bus.flush && !push && nxt_state != FILL_0) begin
            push_group = nxt_acc;
            push       = 1'b1;
            nxt_state  = FILL_0;
            nxt_acc    = '0;
        end
`endif
    end

    // Saturating count of groups dropped because the FIFO was full.
    always_ff @(posedge clk_audio) begin
        if (reset) begin
            bus.overflow_count <= '0;
        end else if (drop && bus.overflow_count != 16'hFFFF) begin
            bus.overflow_count <= bus.overflow_count + 16'd1;
        end
    end

    audio_group_fifo #(.DEPTH(DEPTH), .T(audio_group_t)) u_fifo (
        .clk_audio (clk_audio),
        .reset     (reset),
        .push      (push),
        .push_data (push_group),
        .pop       (pop),
        .head      (head),
        .full      (full),
        .empty     (empty)
    );

    // Outputs: head payload gated to zero while the FIFO is empty.
    always_comb begin
        bus.out_valid         = ~empty;
        bus.out_layout        = LAYOUT;
        dbg_fill_state        = fill_state;
        bus.out_sample        = '0;
        bus.out_present       = '0;
        bus.out_frame_start   = '0;
        bus.out_frame_counter = '0;
        if (!empty) begin
            bus.out_sample        = head.sample;
            bus.out_present       = head.present;
            bus.out_frame_start   = head.frame_start;
            bus.out_frame_counter = head.frame_counter;
        end
    end

endmodule

// File: tb/tb_audio_sample_packer.sv
// Directed bench for audio_sample_packer: 2 ch/16 b, 8 ch/24 b and 6 ch/16 b
// instances sharing one clock and reset. Flush expectations follow
// AUDIO_SAMPLE_PACKER_PARTIAL_FLUSH_EN.
module tb_audio_sample_packer;
    import hdmi_audio_pkg::*;

    logic        clk_audio = 1'b0;
    logic        reset     = 1'b1;
    fill_state_e dbg2, dbg8, dbg6;
    int          vectors     = 0;
    int          miscompares = 0;

    audio_sample_packer_if #(.AUDIO_BIT_WIDTH(16), .CHANNELS(2)) bus2 ();
    audio_sample_packer_if #(.AUDIO_BIT_WIDTH(24), .CHANNELS(8)) bus8 ();
    audio_sample_packer_if #(.AUDIO_BIT_WIDTH(16), .CHANNELS(6)) bus6 ();

    audio_sample_packer #(.AUDIO_BIT_WIDTH(16), .CHANNELS(2), .DEPTH(4)) dut2 (
        .clk_audio(clk_audio), .reset(reset), .bus(bus2), .dbg_fill_state(dbg2));
    audio_sample_packer #(.AUDIO_BIT_WIDTH(24), .CHANNELS(8), .DEPTH(4)) dut8 (
        .clk_audio(clk_audio), .reset(reset), .bus(bus8), .dbg_fill_state(dbg8));
    audio_sample_packer #(.AUDIO_BIT_WIDTH(16), .CHANNELS(6), .DEPTH(4)) dut6 (
        .clk_audio(clk_audio), .reset(reset), .bus(bus6), .dbg_fill_state(dbg6));

    // Clock and reset
    always #5 clk_audio = ~clk_audio;

    // Every task starts and ends 1 time unit after a rising edge.
    task automatic cycle();
        @(posedge clk_audio);
        #1;
    endtask

    task automatic do_reset();
        reset = 1'b1;
        bus2.in_valid = 1'b0; bus8.in_valid = 1'b0; bus6.in_valid = 1'b0;
        bus2.flush = 1'b0; bus8.flush = 1'b0; bus6.flush = 1'b0;
        cycle();
        cycle();
        reset = 1'b0;
    endtask

    // Driver: one 2-channel sample time.
    task automatic put2(input logic [15:0] l, input logic [15:0] r);
        bus2.in_valid     = 1'b1;
        bus2.in_sample[0] = l;
        bus2.in_sample[1] = r;
        cycle();
        bus2.in_valid = 1'b0;
    endtask

    // Driver: four sample times; optionally raise out_ready with the last one.
    task automatic grp2(input logic [15:0] base, input logic rdy_last);
        for (int s = 0; s < 4; s++) begin
            if (s == 3 && rdy_last) bus2.out_ready = 1'b1;
            put2(base + 16'(s), ~(base + 16'(s)));
        end
    endtask

    task automatic test_reset();
        do_reset();
        vectors++; if (bus2.out_valid !== 1'b0) begin miscompares++; $display("FAIL reset_valid2 got %0b exp 0", bus2.out_valid); end
        vectors++; if (bus2.overflow_count !== 16'd0) begin miscompares++; $display("FAIL reset_ovf got %0h exp 0", bus2.overflow_count); end
        vectors++; if (bus2.out_sample !== '0) begin miscompares++; $display("FAIL reset_sample2 got %0h exp 0", bus2.out_sample); end
        vectors++; if (bus2.out_present !== 4'd0) begin miscompares++; $display("FAIL reset_present got %b exp 0000", bus2.out_present); end
        vectors++; if (bus2.out_frame_counter !== 8'd0) begin miscompares++; $display("FAIL reset_fc got %0d exp 0", bus2.out_frame_counter); end
        vectors++; if (dbg2 !== FILL_0) begin miscompares++; $display("FAIL reset_fill got %0d exp 0", dbg2); end
        vectors++; if (bus8.out_valid !== 1'b0) begin miscompares++; $display("FAIL reset_valid8 got %0b exp 0", bus8.out_valid); end
        vectors++; if (bus6.out_sample !== '0) begin miscompares++; $display("FAIL reset_sample6 got %0h exp 0", bus6.out_sample); end
    endtask

    task automatic test_basic_2ch();
        for (int s = 0; s < 3; s++) put2(16'h1234, 16'h00AB + 16'(s));
        vectors++; if (bus2.out_valid !== 1'b0) begin miscompares++; $display("FAIL basic_early_valid got %0b exp 0", bus2.out_valid); end
        vectors++; if (dbg2 !== FILL_3) begin miscompares++; $display("FAIL basic_fill got %0d exp 3", dbg2); end
        put2(16'h1234, 16'h00AE);
        vectors++; if (bus2.out_valid !== 1'b1) begin miscompares++; $display("FAIL basic_valid got %0b exp 1", bus2.out_valid); end
        vectors++; if (bus2.out_sample[0][0] !== 24'h123400) begin miscompares++; $display("FAIL basic_s00 got %h exp 123400", bus2.out_sample[0][0]); end
        vectors++; if (bus2.out_sample[0][1] !== 24'h00AB00) begin miscompares++; $display("FAIL basic_s01 got %h exp 00ab00", bus2.out_sample[0][1]); end
        vectors++; if (bus2.out_sample[3][1] !== 24'h00AE00) begin miscompares++; $display("FAIL basic_s31 got %h exp 00ae00", bus2.out_sample[3][1]); end
        vectors++; if (bus2.out_present !== 4'b1111) begin miscompares++; $display("FAIL basic_present got %b exp 1111", bus2.out_present); end
        vectors++; if (bus2.out_frame_counter !== 8'd0) begin miscompares++; $display("FAIL basic_fc got %0d exp 0", bus2.out_frame_counter); end
        vectors++; if (bus2.out_frame_start !== 4'b0001) begin miscompares++; $display("FAIL basic_fs got %b exp 0001", bus2.out_frame_start); end
        vectors++; if (bus2.out_layout !== 1'b0) begin miscompares++; $display("FAIL basic_layout got %0b exp 0", bus2.out_layout); end
        bus2.out_ready = 1'b1;
        cycle();
        bus2.out_ready = 1'b0;
        vectors++; if (bus2.out_valid !== 1'b0) begin miscompares++; $display("FAIL basic_pop_valid got %0b exp 0", bus2.out_valid); end
        vectors++; if (bus2.out_sample !== '0) begin miscompares++; $display("FAIL basic_pop_zero got %h exp 0", bus2.out_sample); end
    endtask

    task automatic test_frame_wrap();
        logic [7:0] exp_fc;
        do_reset();
        bus2.out_ready = 1'b1;
        for (int g = 0; g < 49; g++) begin
            exp_fc = 8'((g * 4) % 192);
            grp2(16'(g), 1'b0);
            vectors++; if (bus2.out_valid !== 1'b1 || bus2.out_frame_counter !== exp_fc) begin
                miscompares++; $display("FAIL wrap_fc g=%0d got %0d/%0b exp %0d/1", g, bus2.out_frame_counter, bus2.out_valid, exp_fc); end
            vectors++; if (bus2.out_frame_start !== ((exp_fc == 8'd0) ? 4'b0001 : 4'b0000)) begin
                miscompares++; $display("FAIL wrap_fs g=%0d got %b exp fc=%0d", g, bus2.out_frame_start, exp_fc); end
        end
        cycle();
        bus2.out_ready = 1'b0;
    endtask

    task automatic test_layout1_8ch();
        for (int c = 0; c < 8; c++) bus8.in_sample[c] = {8'(c), 16'h0F0F};
        bus8.in_sample[7] = 24'hABCDEF;
        bus8.out_ready = 1'b0;
        bus8.in_valid  = 1'b1;
        cycle();
        vectors++; if (bus8.out_valid !== 1'b1) begin miscompares++; $display("FAIL l8_valid got %0b exp 1", bus8.out_valid); end
        vectors++; if (bus8.out_sample[3][1] !== 24'hABCDEF) begin miscompares++; $display("FAIL l8_s31 got %h exp abcdef", bus8.out_sample[3][1]); end
        vectors++; if (bus8.out_sample[2][0] !== 24'h040F0F) begin miscompares++; $display("FAIL l8_s20 got %h exp 040f0f", bus8.out_sample[2][0]); end
        vectors++; if (bus8.out_present !== 4'b1111) begin miscompares++; $display("FAIL l8_present got %b exp 1111", bus8.out_present); end
        vectors++; if (bus8.out_layout !== 1'b1) begin miscompares++; $display("FAIL l8_layout got %0b exp 1", bus8.out_layout); end
        vectors++; if (bus8.out_frame_start !== 4'b1111) begin miscompares++; $display("FAIL l8_fs got %b exp 1111", bus8.out_frame_start); end
        bus8.out_ready = 1'b1;
        cycle();
        bus8.in_valid = 1'b0;
        vectors++; if (bus8.out_frame_counter !== 8'd1 || bus8.out_frame_start !== 4'b0000) begin
            miscompares++; $display("FAIL l8_second got fc=%0d fs=%b exp fc=1 fs=0000", bus8.out_frame_counter, bus8.out_frame_start); end
        cycle();
        bus8.out_ready = 1'b0;
        vectors++; if (bus8.out_valid !== 1'b0 || bus8.out_sample !== '0) begin
            miscompares++; $display("FAIL l8_empty got valid=%0b exp 0 with zero payload", bus8.out_valid); end
    endtask

    task automatic test_back_to_back_6ch();
        logic [15:0] ch5;
        bus6.out_ready = 1'b1;
        for (int g = 0; g < 3; g++) begin
            for (int c = 0; c < 6; c++) bus6.in_sample[c] = 16'h1000 * 16'(g + 1) + 16'(c);
            ch5 = 16'h1000 * 16'(g + 1) + 16'd5;
            bus6.in_valid = 1'b1;
            cycle();
            vectors++; if (bus6.out_valid !== 1'b1 || bus6.out_present !== 4'b0111) begin
                miscompares++; $display("FAIL l6_present g=%0d got %b exp 0111", g, bus6.out_present); end
            vectors++; if (bus6.out_sample[2][1] !== {ch5, 8'h00} || bus6.out_sample[3] !== '0) begin
                miscompares++; $display("FAIL l6_sample g=%0d got %h exp %h", g, bus6.out_sample[2][1], {ch5, 8'h00}); end
            vectors++; if (bus6.out_frame_counter !== 8'(g) || bus6.out_frame_start !== ((g == 0) ? 4'b0111 : 4'b0000)) begin
                miscompares++; $display("FAIL l6_frame g=%0d got fc=%0d fs=%b", g, bus6.out_frame_counter, bus6.out_frame_start); end
        end
        bus6.in_valid = 1'b0;
        cycle();
        bus6.out_ready = 1'b0;
    endtask

    task automatic test_overflow();
        logic [7:0] exp_fc [4] = '{8'd4, 8'd8, 8'd12, 8'd20};
        do_reset();
        bus2.out_ready = 1'b0;
        for (int g = 0; g < 5; g++) grp2(16'(g * 16), 1'b0);
        vectors++; if (bus2.overflow_count !== 16'd1) begin miscompares++; $display("FAIL ovf_count got %0d exp 1", bus2.overflow_count); end
        vectors++; if (bus2.out_frame_counter !== 8'd0) begin miscompares++; $display("FAIL ovf_head got %0d exp 0", bus2.out_frame_counter); end
        grp2(16'h0500, 1'b1);
        vectors++; if (bus2.overflow_count !== 16'd1) begin miscompares++; $display("FAIL ovf_push_pop got %0d exp 1", bus2.overflow_count); end
        for (int k = 0; k < 4; k++) begin
            vectors++; if (bus2.out_valid !== 1'b1 || bus2.out_frame_counter !== exp_fc[k]) begin
                miscompares++; $display("FAIL ovf_drain k=%0d got %0d exp %0d", k, bus2.out_frame_counter, exp_fc[k]); end
            cycle();
        end
        bus2.out_ready = 1'b0;
        vectors++; if (bus2.out_valid !== 1'b0) begin miscompares++; $display("FAIL ovf_empty got %0b exp 0", bus2.out_valid); end
    endtask

    task automatic test_flush();
        do_reset();
        bus2.out_ready = 1'b0;
        put2(16'hAAAA, 16'h5555);
        put2(16'h0001, 16'h0002);
        bus2.flush = 1'b1;
        cycle();
        bus2.flush = 1'b0;
`ifdef AUDIO_SAMPLE_PACKER_PARTIAL_FLUSH_EN
        vectors++; if (bus2.out_valid !== 1'b1 || bus2.out_present !== 4'b0011) begin
            miscompares++; $display("FAIL flush_present got %b valid=%0b exp 0011", bus2.out_present, bus2.out_valid); end
        vectors++; if (bus2.out_sample[1][0] !== 24'h000100 || bus2.out_sample[0][1] !== 24'h555500) begin
            miscompares++; $display("FAIL flush_data got %h/%h exp 000100/555500", bus2.out_sample[1][0], bus2.out_sample[0][1]); end
        vectors++; if (bus2.out_sample[2] !== '0 || bus2.out_sample[3] !== '0) begin
            miscompares++; $display("FAIL flush_zero got %h exp 0", bus2.out_sample[3:2]); end
        vectors++; if (dbg2 !== FILL_0 || bus2.out_frame_start !== 4'b0001) begin
            miscompares++; $display("FAIL flush_fill got %0d fs=%b exp 0 fs=0001", dbg2, bus2.out_frame_start); end
        bus2.out_ready = 1'b1;
        cycle();
        bus2.out_ready = 1'b0;
        grp2(16'h0700, 1'b0);
        vectors++; if (bus2.out_present !== 4'b1111 || bus2.out_frame_counter !== 8'd2) begin
            miscompares++; $display("FAIL flush_next got %b fc=%0d exp 1111 fc=2", bus2.out_present, bus2.out_frame_counter); end
`else
        vectors++; if (bus2.out_valid !== 1'b0) begin miscompares++; $display("FAIL flush_ignored got %0b exp 0", bus2.out_valid); end
        vectors++; if (dbg2 !== FILL_2) begin miscompares++; $display("FAIL flush_fill got %0d exp 2", dbg2); end
`endif
    endtask

    task automatic test_reset_mid_group();
        do_reset();
        put2(16'h0BAD, 16'h0BAD);
        do_reset();
        grp2(16'h0C00, 1'b0);
        vectors++; if (bus2.out_valid !== 1'b1 || bus2.out_frame_counter !== 8'd0) begin
            miscompares++; $display("FAIL midreset_fc got %0d valid=%0b exp 0", bus2.out_frame_counter, bus2.out_valid); end
        vectors++; if (bus2.out_sample[0][0] !== 24'h0C0000 || bus2.out_present !== 4'b1111) begin
            miscompares++; $display("FAIL midreset_s00 got %h exp 0c0000", bus2.out_sample[0][0]); end
    endtask

    initial begin
        bus2.in_valid = 1'b0; bus2.in_sample = '0; bus2.flush = 1'b0; bus2.out_ready = 1'b0;
        bus8.in_valid = 1'b0; bus8.in_sample = '0; bus8.flush = 1'b0; bus8.out_ready = 1'b0;
        bus6.in_valid = 1'b0; bus6.in_sample = '0; bus6.flush = 1'b0; bus6.out_ready = 1'b0;
        @(posedge clk_audio);
        #1;
        test_reset();
        test_basic_2ch();
        test_frame_wrap();
        test_layout1_8ch();
        test_back_to_back_6ch();
        test_overflow();
        test_flush();
        test_reset_mid_group();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
